fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 45 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of memory, instruction-handoff and branch-resolution signals between
// the fetch unit (master) and its surrounding core/memory (slave).
interface fetch_unit_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  // Handshakes: a read is outstanding while mem_cmd==01; it completes on the
  // cycle mem_ready=1. An instruction is offered while instr_valid=1 and is
  // consumed on the cycle instr_ack=1; instr stays stable until then.
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ack;
  logic              br_req;
  logic [1:0]        br_kind;
  logic [2:0]        br_cond;
  logic              flag_n;
  logic              flag_v;
  logic              flag_z;
  logic [DATA_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] link_pc;
  logic              link_valid;
  logic              halt;
  logic              halted;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;

  modport master (
    output mem_cmd, mem_addr, instr, instr_valid, link_pc, link_valid,
           halted, pc, fetch_err,
    input  mem_rdata, mem_ready, instr_ack, br_req, br_kind, br_cond,
           flag_n, flag_v, flag_z, br_offset, br_target, halt
  );

  modport slave (
    input  mem_cmd, mem_addr, instr, instr_valid, link_pc, link_valid,
           halted, pc, fetch_err,
    output mem_rdata, mem_ready, instr_ack, br_req, br_kind, br_cond,
           flag_n, flag_v, flag_z, br_offset, br_target, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: reads one word, holds it for the core, then
// resolves an optional branch/halt on acknowledge before fetching again.
module fetch_unit #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 7
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus,
  output logic [2:0]    dbg_state_o
);

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam int                CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              fetch_err_q, fetch_err_d;
  logic [ADDR_W-1:0] link_pc_q, link_pc_d;
  logic              link_valid_q, link_valid_d;
  logic              br_taken;

  always_comb begin
    br_taken = 1'b0;
    unique case (bus.br_cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = bus.flag_z;
      3'b010:  br_taken = !bus.flag_z;
      3'b011:  br_taken = bus.flag_n ^ bus.flag_v;
      3'b100:  br_taken = (bus.flag_n ^ bus.flag_v) | bus.flag_z;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    wait_cnt_d   = wait_cnt_q;
    fetch_err_d  = fetch_err_q;
    link_pc_d    = link_pc_q;
    link_valid_d = 1'b0;
    unique case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          instr_d = bus.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_HOLD;
        end else if (wait_cnt_q == WAIT_LIM) begin
          fetch_err_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // halt wins over a simultaneous branch and leaves pc untouched
        if (bus.instr_ack) begin
          if (bus.halt) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
            if (bus.br_req && br_taken) begin
              pc_d = bus.br_kind[0] ? bus.br_target
                                    : pc_q + bus.br_offset[ADDR_W-1:0];
              if (bus.br_kind[1]) begin
                link_pc_d    = pc_q;
                link_valid_d = 1'b1;
              end
            end
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      wait_cnt_q   <= '0;
      fetch_err_q  <= 1'b0;
      link_pc_q    <= '0;
      link_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      wait_cnt_q   <= wait_cnt_d;
      fetch_err_q  <= fetch_err_d;
      link_pc_q    <= link_pc_d;
      link_valid_q <= link_valid_d;
    end
  end

  // mem_cmd decodes straight from state so an async reset drops the read at once
  assign bus.mem_cmd     = (state_q == ST_FETCH || state_q == ST_WAIT) ? 2'b01 : 2'b00;
  assign bus.mem_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.link_pc     = link_pc_q;
  assign bus.link_valid  = link_valid_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.pc          = pc_q;
  assign bus.fetch_err   = fetch_err_q;
  assign dbg_state_o     = state_q;

endmodule
